// File: rtl/sensor_hub_ctrl.sv
// Host command controller for N DHT11-class sensor channels behind a UART byte link.
// Decodes (cmd, addr) pairs, measures one channel, replies (code, data); adds continuous polling and timeouts.
module sensor_hub_ctrl #(
    parameter int N_CH        = 8,
    parameter int POLL_CYC    = 100_000_000,
    parameter int SNS_TO_CYC  = 50_000_000,
    parameter int BYTE_TO_CYC = 5_000_000
) (
    input  logic                 i_Clock,
    input  logic                 rst_n,
    input  logic [7:0]           i_Rx_Data,
    input  logic                 i_Rx_Done,
    input  logic                 i_Tx_Busy,
    input  logic                 i_Tx_Done,
    output logic [7:0]           o_Tx_Data,
    output logic                 o_Tx_Start,
    input  logic [32*N_CH-1:0]   i_Sns_Data,
    input  logic [N_CH-1:0]      i_Sns_Done,
    input  logic [N_CH-1:0]      i_Sns_Error,
    output logic [N_CH-1:0]      o_Sns_Start,
    output logic [N_CH-1:0]      o_Cont_Mask,
    output logic                 o_Rx_Drop,
    output logic [3:0]           o_State
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_RX_ADDR   = 4'd1;
    localparam logic [3:0] ST_CHECK     = 4'd2;
    localparam logic [3:0] ST_MEASURE   = 4'd3;
    localparam logic [3:0] ST_SEND_CODE = 4'd4;
    localparam logic [3:0] ST_WAIT_CODE = 4'd5;
    localparam logic [3:0] ST_SEND_DATA = 4'd6;
    localparam logic [3:0] ST_WAIT_DATA = 4'd7;

    localparam logic [7:0] CMD_STATUS   = 8'h00;
    localparam logic [7:0] CMD_HUM_INT  = 8'h01;
    localparam logic [7:0] CMD_HUM_FRAC = 8'h02;
    localparam logic [7:0] CMD_TMP_INT  = 8'h03;
    localparam logic [7:0] CMD_TMP_FRAC = 8'h04;
    localparam logic [7:0] CMD_CONT_ON  = 8'h05;
    localparam logic [7:0] CMD_CONT_OFF = 8'h06;

    localparam logic [7:0] RSP_OK       = 8'h07;
    localparam logic [7:0] RSP_HUM      = 8'h08;
    localparam logic [7:0] RSP_TMP      = 8'h09;
    localparam logic [7:0] RSP_CONT_ON  = 8'h0A;
    localparam logic [7:0] RSP_CONT_OFF = 8'h0B;
    localparam logic [7:0] RSP_SNS_ERR  = 8'h1F;
    localparam logic [7:0] RSP_BAD_ADDR = 8'hFE;
    localparam logic [7:0] RSP_BAD_CMD  = 8'hFF;

    localparam logic [7:0]  N_CH_B    = 8'(N_CH);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
    localparam logic [31:0] SNS_LAST  = 32'(SNS_TO_CYC - 1);
    localparam logic [31:0] BYTE_LAST = 32'(BYTE_TO_CYC - 1);

    logic [3:0]      state_reg;
    logic [7:0]      cmd_reg;
    logic [7:0]      addr_reg;
    logic            bad_reg;
    logic [7:0]      code_reg;
    logic [7:0]      data_reg;
    logic [31:0]     byte_cnt_reg;
    logic [31:0]     sns_cnt_reg;
    logic [31:0]     poll_cnt_reg;
    logic            poll_pending_reg;
    logic [CH_W-1:0] last_poll_reg;
    logic [N_CH-1:0] mask_reg;
    logic [7:0]      tx_data_reg;
    logic            tx_start_reg;
    logic            rx_drop_reg;

    logic [CH_W-1:0] addr_idx;
    logic [N_CH-1:0] ch_sel;
    logic [31:0]     ch_data [N_CH];
    logic            meas_active;
    logic            act_done;
    logic            act_err;
    logic [31:0]     act_data;
    logic [7:0]      meas_code_next;
    logic [7:0]      meas_val_next;
    logic            pick_found_next;
    logic [CH_W-1:0] pick_ch_next;

    assign addr_idx    = addr_reg[CH_W-1:0];
    assign meas_active = (state_reg == ST_MEASURE);

    // Start is decoded straight from the state register so it falls with the async reset.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ch_data[gi]     = i_Sns_Data[32*gi +: 32];
        assign ch_sel[gi]      = (addr_idx == CH_W'(gi));
        assign o_Sns_Start[gi] = meas_active && ch_sel[gi];
    end

    assign act_done = |(i_Sns_Done & ch_sel);
    assign act_err  = |(i_Sns_Error & ch_sel);

    always_comb begin
        act_data = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel[i]) begin
                act_data = ch_data[i];
            end
        end
    end

    always_comb begin
        meas_code_next = RSP_OK;
        meas_val_next  = 8'h00;
        case (cmd_reg)
            CMD_HUM_INT: begin
                meas_code_next = RSP_HUM;
                meas_val_next  = act_data[31:24];
            end
            CMD_HUM_FRAC: begin
                meas_code_next = RSP_HUM;
                meas_val_next  = act_data[23:16];
            end
            CMD_TMP_INT: begin
                meas_code_next = RSP_TMP;
                meas_val_next  = act_data[15:8];
            end
            CMD_TMP_FRAC: begin
                meas_code_next = RSP_TMP;
                meas_val_next  = act_data[7:0];
            end
            CMD_CONT_ON: begin
                meas_code_next = RSP_CONT_ON;
                meas_val_next  = act_data[15:8];
            end
            default: begin
                meas_code_next = RSP_OK;
                meas_val_next  = 8'h00;
            end
        endcase
    end

    // Round-robin search starting just after the last polled channel.
    always_comb begin
        logic [CH_W:0] idx;
        pick_found_next = 1'b0;
        pick_ch_next    = '0;
        idx             = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = {1'b0, last_poll_reg} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            if (!pick_found_next && mask_reg[idx[CH_W-1:0]]) begin
                pick_found_next = 1'b1;
                pick_ch_next    = idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cmd_reg          <= 8'h00;
            addr_reg         <= 8'h00;
            bad_reg          <= 1'b0;
            code_reg         <= 8'h00;
            data_reg         <= 8'h00;
            byte_cnt_reg     <= 32'h0;
            sns_cnt_reg      <= 32'h0;
            poll_cnt_reg     <= 32'h0;
            poll_pending_reg <= 1'b0;
            last_poll_reg    <= CH_W'(N_CH - 1);
            mask_reg         <= '0;
            tx_data_reg      <= 8'h00;
            tx_start_reg     <= 1'b0;
            rx_drop_reg      <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            rx_drop_reg  <= 1'b0;

            // Pending is a single sticky flag, so wraps while busy collapse into one poll.
            if (poll_cnt_reg == POLL_LAST) begin
                poll_cnt_reg <= 32'h0;
                if (mask_reg != '0) begin
                    poll_pending_reg <= 1'b1;
                end
            end else begin
                poll_cnt_reg <= poll_cnt_reg + 32'd1;
            end

            if (i_Rx_Done && (state_reg != ST_IDLE) && (state_reg != ST_RX_ADDR)) begin
                rx_drop_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (i_Rx_Done) begin
                        cmd_reg      <= i_Rx_Data;
                        byte_cnt_reg <= 32'h0;
                        state_reg    <= ST_RX_ADDR;
                    end else if (poll_pending_reg) begin
                        poll_pending_reg <= 1'b0;
                        if (pick_found_next) begin
                            cmd_reg       <= CMD_CONT_ON;
                            addr_reg      <= {{(8-CH_W){1'b0}}, pick_ch_next};
                            last_poll_reg <= pick_ch_next;
                            bad_reg       <= 1'b0;
                            sns_cnt_reg   <= 32'h0;
                            state_reg     <= ST_MEASURE;
                        end
                    end
                end
                ST_RX_ADDR: begin
                    if (i_Rx_Done) begin
                        addr_reg  <= i_Rx_Data;
                        state_reg <= ST_CHECK;
                    end else if (byte_cnt_reg == BYTE_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 32'd1;
                    end
                end
                ST_CHECK: begin
                    if (cmd_reg > CMD_CONT_OFF) begin
                        bad_reg   <= 1'b1;
                        code_reg  <= RSP_BAD_CMD;
                        data_reg  <= cmd_reg;
                        state_reg <= ST_SEND_CODE;
                    end else if (addr_reg >= N_CH_B) begin
                        bad_reg   <= 1'b1;
                        code_reg  <= RSP_BAD_ADDR;
                        data_reg  <= addr_reg;
                        state_reg <= ST_SEND_CODE;
                    end else if (cmd_reg == CMD_CONT_OFF) begin
                        bad_reg   <= 1'b0;
                        code_reg  <= RSP_CONT_OFF;
                        data_reg  <= 8'h00;
                        state_reg <= ST_SEND_CODE;
                    end else begin
                        bad_reg     <= 1'b0;
                        sns_cnt_reg <= 32'h0;
                        state_reg   <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // Error beats done; done in the final cycle still beats the timeout.
                    if (act_err) begin
                        code_reg  <= RSP_SNS_ERR;
                        data_reg  <= 8'h00;
                        state_reg <= ST_SEND_CODE;
                    end else if (act_done) begin
                        code_reg  <= meas_code_next;
                        data_reg  <= meas_val_next;
                        state_reg <= ST_SEND_CODE;
                    end else if (sns_cnt_reg == SNS_LAST) begin
                        code_reg  <= RSP_SNS_ERR;
                        data_reg  <= 8'h00;
                        state_reg <= ST_SEND_CODE;
                    end else begin
                        sns_cnt_reg <= sns_cnt_reg + 32'd1;
                    end
                end
                ST_SEND_CODE: begin
                    if (!i_Tx_Busy) begin
                        tx_data_reg  <= code_reg;
                        tx_start_reg <= 1'b1;
                        state_reg    <= ST_WAIT_CODE;
                        if (!bad_reg && (cmd_reg == CMD_CONT_ON)) begin
                            mask_reg[addr_idx] <= 1'b1;
                        end
                        if (!bad_reg && (cmd_reg == CMD_CONT_OFF)) begin
                            mask_reg[addr_idx] <= 1'b0;
                        end
                    end
                end
                ST_WAIT_CODE: begin
                    if (i_Tx_Done) begin
                        state_reg <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (!i_Tx_Busy) begin
                        tx_data_reg  <= data_reg;
                        tx_start_reg <= 1'b1;
                        state_reg    <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (i_Tx_Done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Tx_Data   = tx_data_reg;
    assign o_Tx_Start  = tx_start_reg;
    assign o_Cont_Mask = mask_reg;
    assign o_Rx_Drop   = rx_drop_reg;
    assign o_State     = state_reg;

endmodule

// File: tb/tb_sensor_hub_ctrl.sv
// Directed bench for sensor_hub_ctrl: UART tx and sensor responder models, reply bytes checked via a scoreboard queue.
module tb_sensor_hub_ctrl;
    localparam int N_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           i_Rx_Data;
    logic                 i_Rx_Done;
    logic                 i_Tx_Busy;
    logic                 i_Tx_Done;
    logic [7:0]           o_Tx_Data;
    logic                 o_Tx_Start;
    logic [32*N_CH-1:0]   i_Sns_Data;
    logic [N_CH-1:0]      i_Sns_Done;
    logic [N_CH-1:0]      i_Sns_Error;
    logic [N_CH-1:0]      o_Sns_Start;
    logic [N_CH-1:0]      o_Cont_Mask;
    logic                 o_Rx_Drop;
    logic [3:0]           o_State;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    int tx_bytes = 0;
    int start_rises = 0;
    int last_start_len = 0;
    int last_start_ch = -1;
    int sns_mode [N_CH];   // 0 silent, 1 done, 2 error, 3 done+error
    int sns_delay [N_CH];

    sensor_hub_ctrl #(
        .N_CH(N_CH), .POLL_CYC(1000), .SNS_TO_CYC(200), .BYTE_TO_CYC(50)
    ) dut (
        .i_Clock(clk), .rst_n(rst_n),
        .i_Rx_Data(i_Rx_Data), .i_Rx_Done(i_Rx_Done),
        .i_Tx_Busy(i_Tx_Busy), .i_Tx_Done(i_Tx_Done),
        .o_Tx_Data(o_Tx_Data), .o_Tx_Start(o_Tx_Start),
        .i_Sns_Data(i_Sns_Data), .i_Sns_Done(i_Sns_Done), .i_Sns_Error(i_Sns_Error),
        .o_Sns_Start(o_Sns_Start), .o_Cont_Mask(o_Cont_Mask),
        .o_Rx_Drop(o_Rx_Drop), .o_State(o_State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_Rx_Data = b;
        i_Rx_Done = 1'b1;
        @(negedge clk);
        i_Rx_Done = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] code, input logic [7:0] data);
        exp_q.push_back(code);
        exp_q.push_back(data);
        send_byte(c);
        send_byte(a);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_State != 4'd0 || i_Tx_Busy) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 6000) else begin
            errors++;
            $error("FAIL %s_timeout: waited %0d cycles, limit 6000", tag, n);
        end
        repeat (2) @(negedge clk);
    endtask

    // UART transmitter: each start pops the scoreboard, stays busy 8 cycles, then pulses done.
    initial begin : uart_tx_model
        logic [7:0] sent;
        logic [7:0] want;
        i_Tx_Busy = 1'b0;
        i_Tx_Done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_Tx_Start === 1'b1) begin
                sent = o_Tx_Data;
                tx_bytes++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL tx_unexpected: observed byte %02h, expected no byte", sent);
                end
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("tx_byte", 32'(sent), 32'(want));
                    $display("tx byte %02h expected %02h at %0t", sent, want, $time);
                end
                i_Tx_Busy = 1'b1;
                repeat (8) @(negedge clk);
                check("tx_hold", 32'(o_Tx_Data), 32'(sent));
                i_Tx_Done = 1'b1;
                i_Tx_Busy = 1'b0;
                @(negedge clk);
                i_Tx_Done = 1'b0;
            end
        end
    end

    // Sensor responder: answers the started channel after sns_delay cycles, level held until Start drops.
    initial begin : sensor_model
        int cnt;
        int ch;
        cnt = 0;
        i_Sns_Done = '0;
        i_Sns_Error = '0;
        forever begin
            @(negedge clk);
            if (o_Sns_Start != '0) begin
                cnt++;
                ch = 0;
                for (int k = 0; k < N_CH; k++) if (o_Sns_Start[k]) ch = k;
                if (cnt >= sns_delay[ch]) begin
                    if (sns_mode[ch] == 1 || sns_mode[ch] == 3) i_Sns_Done[ch] = 1'b1;
                    if (sns_mode[ch] >= 2) i_Sns_Error[ch] = 1'b1;
                end
            end else begin
                cnt = 0;
                i_Sns_Done = '0;
                i_Sns_Error = '0;
            end
        end
    end

    initial begin : start_monitor
        logic [N_CH-1:0] prev;
        int len;
        prev = '0;
        len = 0;
        forever begin
            @(negedge clk);
            assert ($onehot0(o_Sns_Start)) else begin
                errors++;
                $error("FAIL start_onehot: observed %b expected one-hot or zero", o_Sns_Start);
            end
            if (o_Sns_Start != '0) begin
                if (prev == '0) begin
                    start_rises++;
                    len = 0;
                end
                len++;
            end else if (prev != '0) begin
                last_start_len = len;
                for (int k = 0; k < N_CH; k++) if (prev[k]) last_start_ch = k;
            end
            prev = o_Sns_Start;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int rises0;
        int bytes0;
        int n;
        rst_n = 1'b0;
        i_Rx_Data = 8'h00;
        i_Rx_Done = 1'b0;
        i_Sns_Data = {32'h55_66_77_88, 32'h37_00_19_00, 32'hAA_BB_CC_DD, 32'h11_22_33_44};
        for (int k = 0; k < N_CH; k++) begin
            sns_mode[k] = 1;
            sns_delay[k] = 5;
        end
        sns_delay[2] = 100;
        sns_mode[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_tx_data", 32'(o_Tx_Data), 32'h00);
        check("rst_tx_start", 32'(o_Tx_Start), 32'h0);
        check("rst_sns_start", 32'(o_Sns_Start), 32'h0);
        check("rst_cont_mask", 32'(o_Cont_Mask), 32'h0);
        check("rst_rx_drop", 32'(o_Rx_Drop), 32'h0);
        check("rst_state", 32'(o_State), 32'h0);
        rst_n = 1'b1;

        send_cmd(8'h03, 8'h02, 8'h09, 8'h19);
        wait_idle("tmp_int_ch2");
        check("start_len_ch2", 32'(last_start_len), 32'd100);
        check("start_ch_ch2", 32'(last_start_ch), 32'd2);

        rises0 = start_rises;
        send_cmd(8'h01, 8'h07, 8'hFE, 8'h07);
        wait_idle("bad_addr_07");
        send_cmd(8'h01, 8'h04, 8'hFE, 8'h04);
        wait_idle("bad_addr_04");
        send_cmd(8'h0C, 8'h01, 8'hFF, 8'h0C);
        wait_idle("bad_cmd_0c");
        send_cmd(8'h07, 8'h00, 8'hFF, 8'h07);
        wait_idle("bad_cmd_07");
        send_cmd(8'h06, 8'h02, 8'h0B, 8'h00);
        wait_idle("cont_off");
        check("no_start_on_reject", 32'(start_rises), 32'(rises0));
        check("mask_after_off", 32'(o_Cont_Mask), 32'h0);

        send_cmd(8'h00, 8'h01, 8'h1F, 8'h00);
        wait_idle("timeout_ch1");
        check("start_len_timeout", 32'(last_start_len), 32'd200);
        check("start_ch_timeout", 32'(last_start_ch), 32'd1);

        send_cmd(8'h00, 8'h03, 8'h07, 8'h00);
        wait_idle("status_ch3");
        send_cmd(8'h02, 8'h00, 8'h08, 8'h22);
        wait_idle("hum_frac_ch0");
        send_cmd(8'h04, 8'h03, 8'h09, 8'h88);
        wait_idle("tmp_frac_ch3");
        send_cmd(8'h01, 8'h02, 8'h08, 8'h37);
        wait_idle("hum_int_ch2");
        sns_mode[0] = 3;
        send_cmd(8'h00, 8'h00, 8'h1F, 8'h00);
        wait_idle("err_beats_done");
        sns_mode[0] = 1;
        sns_mode[3] = 2;
        send_cmd(8'h03, 8'h03, 8'h1F, 8'h00);
        wait_idle("err_ch3");
        sns_mode[3] = 1;

        bytes0 = tx_bytes;
        send_byte(8'h02);
        repeat (40) @(negedge clk);
        check("stale_still_rx_addr", 32'(o_State), 32'd1);
        repeat (15) @(negedge clk);
        check("stale_back_idle", 32'(o_State), 32'd0);
        check("stale_no_tx", 32'(tx_bytes), 32'(bytes0));
        send_cmd(8'h03, 8'h02, 8'h09, 8'h19);
        wait_idle("after_stale");

        send_cmd(8'h00, 8'h03, 8'h07, 8'h00);
        n = 0;
        while (o_State != 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_data", 32'(o_State), 32'd7);
        send_byte(8'h5A);
        check("rx_drop_pulse", 32'(o_Rx_Drop), 32'h1);
        @(negedge clk);
        check("rx_drop_clear", 32'(o_Rx_Drop), 32'h0);
        wait_idle("drop_reply");

        send_byte(8'h00);
        send_byte(8'h01);
        n = 0;
        while (o_Sns_Start[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_measuring", 32'(o_Sns_Start), 32'h2);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sns_start", 32'(o_Sns_Start), 32'h0);
        check("midrst_tx_start", 32'(o_Tx_Start), 32'h0);
        check("midrst_state", 32'(o_State), 32'h0);
        check("midrst_mask", 32'(o_Cont_Mask), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send_cmd(8'h05, 8'h00, 8'h0A, 8'h33);
        wait_idle("cont_on_ch0");
        check("mask_ch0", 32'(o_Cont_Mask), 32'h1);
        send_cmd(8'h05, 8'h03, 8'h0A, 8'h77);
        wait_idle("cont_on_ch3");
        check("mask_ch0_ch3", 32'(o_Cont_Mask), 32'h9);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h33);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h77);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h33);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h77);
        wait_idle("polls");
        check("last_poll_ch", 32'(last_start_ch), 32'd3);

        rst_n = 1'b0;
        #1;
        check("final_rst_mask", 32'(o_Cont_Mask), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
